// File: rtl/up2_ram.sv
// Request/ack register-array RAM: level requests, one-cycle acks after LATENCY+1 cycles.
// Write wins a simultaneous request (o_err pulse); dropping the request during WAIT aborts.
module up2_ram #(
  parameter int ADDR_NIBBLES = 1,
  parameter int DATA_NIBBLES = 1,
  parameter int LATENCY      = 0,
  localparam int ADDR_WIDTH  = 4 * ADDR_NIBBLES,
  localparam int DATA_WIDTH  = 4 * DATA_NIBBLES,
  localparam int DEPTH       = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  i_read_req,
  output logic                  o_read_ack,
  input  logic                  i_write_req,
  output logic                  o_write_ack,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_op_wr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_read_ack;
  logic                  r_write_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_fire;
  logic w_dec;
  logic w_held;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    w_dec    = 1'b0;
    w_held   = r_op_wr ? i_write_req : i_read_req;
    case (r_state)
      S_IDLE: begin
        if (i_read_req || i_write_req) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        // A withdrawn request takes priority over completion.
        if (!w_held) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_fire = 1'b1;
          w_next = S_ACK;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_op_wr     <= 1'b0;
      r_rdata     <= '0;
      r_read_ack  <= 1'b0;
      r_write_ack <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_read_ack  <= w_fire & ~r_op_wr;
      r_write_ack <= w_fire & r_op_wr;
      r_err       <= w_accept & i_read_req & i_write_req;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_data  <= i_data;
        r_op_wr <= i_write_req;
        r_cnt   <= LAT;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire) begin
        if (r_op_wr) r_mem[r_addr] <= r_data;
        else         r_rdata       <= r_mem[r_addr];
      end
    end
  end

  assign o_read_ack  = r_read_ack;
  assign o_write_ack = r_write_ack;
  assign o_data      = r_rdata;
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_up2_ram.sv
// Directed bench for up2_ram: LATENCY=2 instance for the table and corner sequences,
// LATENCY=0 instance for back-to-back ack spacing.
module tb_up2_ram;

  logic       clk = 1'b0;
  logic       nRst;
  logic       rd, wr, rd0, wr0;
  logic [3:0] addr, din, addr0, din0;
  logic       rack, wack, busy, err, rack0, wack0, busy0, err0;
  logic [3:0] dout, dout0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] last_rd;

  always #5 clk = ~clk;

  up2_ram #(.ADDR_NIBBLES(1), .DATA_NIBBLES(1), .LATENCY(2)) u_dut (
    .clk(clk), .nRst(nRst), .i_read_req(rd), .o_read_ack(rack), .i_write_req(wr),
    .o_write_ack(wack), .i_addr(addr), .i_data(din), .o_data(dout), .o_busy(busy), .o_err(err));

  up2_ram #(.ADDR_NIBBLES(1), .DATA_NIBBLES(1), .LATENCY(0)) u_dut0 (
    .clk(clk), .nRst(nRst), .i_read_req(rd0), .o_read_ack(rack0), .i_write_req(wr0),
    .o_write_ack(wack0), .i_addr(addr0), .i_data(din0), .o_data(dout0), .o_busy(busy0), .o_err(err0));

  typedef struct {
    bit         is_wr;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Counts negedges until the selected ack is seen; 40 means it never came.
  task automatic wait_ack(input bit sel0, input bit is_wr, output int n);
    logic a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (sel0) a = is_wr ? wack0 : rack0;
      else      a = is_wr ? wack : rack;
    end while (!a && n < 40);
    if (!a) check("ack_timeout", 0, 1);
  endtask

  task automatic run_xfer(input bit is_wr, input logic [3:0] a, input logic [3:0] d,
                          input logic [3:0] exp);
    int n;
    addr = a; din = d;
    if (is_wr) wr = 1'b1; else rd = 1'b1;
    wait_ack(1'b0, is_wr, n);
    check(is_wr ? "wr_latency" : "rd_latency", n, 4);
    check("other_ack_low", int'(is_wr ? rack : wack), 0);
    if (is_wr) begin
      check("data_hold_over_write", int'(dout), int'(last_rd));
    end else begin
      check("rd_data", int'(dout), int'(exp));
      last_rd = exp;
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", int'(rack | wack), 0);
    check("idle_after_ack", int'(busy), 0);
  endtask

  initial begin
    int  n;
    bit  seen;

    tbl[0] = '{1'b0, 4'h5, 4'h0, 4'h0};
    tbl[1] = '{1'b1, 4'h3, 4'hA, 4'h0};
    tbl[2] = '{1'b0, 4'h3, 4'h0, 4'hA};
    tbl[3] = '{1'b1, 4'hF, 4'h5, 4'h0};
    tbl[4] = '{1'b0, 4'hF, 4'h0, 4'h5};
    tbl[5] = '{1'b0, 4'h3, 4'h0, 4'hA};
    tbl[6] = '{1'b1, 4'h0, 4'h1, 4'h0};
    tbl[7] = '{1'b0, 4'h0, 4'h0, 4'h1};
    tbl[8] = '{1'b1, 4'h0, 4'hE, 4'h0};
    tbl[9] = '{1'b0, 4'h0, 4'h0, 4'hE};

    nRst = 1'b0;
    rd = 0; wr = 0; addr = 0; din = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; din0 = 0;
    last_rd = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({rack, wack, busy, err, dout}), 0);
    check("rst_outputs0", int'({rack0, wack0, busy0, err0, dout0}), 0);
    nRst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_xfer(tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].exp);

    // Simultaneous requests: write first with o_err, then the held read.
    addr = 4'h7; din = 4'hC; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    check("err_pulse", int'(err), 1);
    check("busy_in_wait", int'(busy), 1);
    @(negedge clk);
    check("err_one_cycle", int'(err), 0);
    wait_ack(1'b0, 1'b1, n);
    check("both_wr_latency", n, 2);
    check("both_no_rack", int'(rack), 0);
    wr = 1'b0;
    wait_ack(1'b0, 1'b0, n);
    check("both_rd_latency", n, 5);
    check("both_rd_data", int'(dout), 12);
    rd = 1'b0;
    last_rd = 4'hC;
    @(negedge clk);

    // Abort: read of 0x3 withdrawn mid-WAIT.
    addr = 4'h3; rd = 1'b1;
    repeat (2) @(negedge clk);
    rd = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rack || wack) seen = 1;
    end
    check("abort_no_ack", int'(seen), 0);
    check("abort_idle", int'(busy), 0);
    check("abort_data_hold", int'(dout), 12);

    // Reset during WAIT of a write.
    addr = 4'h1; din = 4'h9; wr = 1'b1;
    repeat (2) @(negedge clk);
    nRst = 1'b0; wr = 1'b0;
    #1;
    check("midrst_outputs", int'({rack, wack, busy, err, dout}), 0);
    @(negedge clk);
    nRst = 1'b1;
    last_rd = 4'h0;
    @(negedge clk);
    check("midrst_no_ack", int'(rack | wack), 0);
    run_xfer(1'b0, 4'h1, 4'h0, 4'h0);

    // LATENCY=0 swap sequence.
    addr0 = 4'h4; din0 = 4'h7; rd0 = 1'b1;
    wait_ack(1'b1, 1'b0, n);
    check("l0_rd_latency", n, 2);
    check("l0_rd_data", int'(dout0), 0);
    rd0 = 1'b0; wr0 = 1'b1;
    @(negedge clk);
    check("l0_idle_gap", int'(busy0 | rack0 | wack0), 0);
    wait_ack(1'b1, 1'b1, n);
    check("l0_wr_gap", n, 2);
    wr0 = 1'b0; rd0 = 1'b1;
    wait_ack(1'b1, 1'b0, n);
    check("l0_rd2_gap", n, 3);
    check("l0_rd2_data", int'(dout0), 7);
    rd0 = 1'b0;
    @(negedge clk);
    check("l0_ack_one_cycle", int'(rack0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up2_ram.md
UP2_RAM -- requirements
Module: up2_ram

Interface
REQ-001 The block SHALL have parameter ADDR_NIBBLES, default 1, meaning the address width in nibbles.
REQ-002 The block SHALL have parameter DATA_NIBBLES, default 1, meaning the data width in nibbles.
REQ-003 The block SHALL have parameter LATENCY, default 0, range 0..15, meaning the number of wait cycles between request acceptance and ack.
REQ-004 The block SHALL derive ADDR_WIDTH = 4*ADDR_NIBBLES, DATA_WIDTH = 4*DATA_NIBBLES and DEPTH = 2^ADDR_WIDTH.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port nRst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port i_read_req, input, 1 bit: level read request, held by the initiator until ack.
REQ-008 Port o_read_ack, output, 1 bit: single-cycle read acknowledge.
REQ-009 Port i_write_req, input, 1 bit: level write request, held by the initiator until ack.
REQ-010 Port o_write_ack, output, 1 bit: single-cycle write acknowledge.
REQ-011 Port i_addr, input, ADDR_WIDTH bits: request address.
REQ-012 Port i_data, input, DATA_WIDTH bits: write data.
REQ-013 Port o_data, output, DATA_WIDTH bits: read data, registered.
REQ-014 Port o_busy, output, 1 bit: high while a request is in progress (WAIT or ACK state).
REQ-015 Port o_err, output, 1 bit: single-cycle pulse flagging simultaneous read and write requests.

Function
REQ-016 Storage SHALL be a DEPTH x DATA_WIDTH register array.
REQ-017 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-018 In IDLE with either request high, the block SHALL latch i_addr, i_data and the op type, load a counter with LATENCY, and go to WAIT.
REQ-019 If both requests are high in IDLE, the block SHALL accept the write and pulse o_err for one cycle; the read stays pending and is accepted later from IDLE.
REQ-020 In WAIT the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to ACK, so the ack is high exactly LATENCY+1 cycles after the accept edge.
REQ-021 In WAIT, if the latched op's request is low, the block SHALL abort to IDLE with no ack, no memory write and no o_data change.
REQ-022 The WAIT->ACK edge for a read SHALL load o_data with mem[latched addr], so o_data is valid in the ack cycle.
REQ-023 The WAIT->ACK edge for a write SHALL write the latched data into mem[latched addr].
REQ-024 o_read_ack/o_write_ack SHALL be registered, high for exactly the one cycle spent in ACK, and mutually exclusive.
REQ-025 ACK SHALL always return to IDLE, ignoring requests in that cycle; a request held or newly raised is accepted the following cycle, so there is a minimum of one idle cycle between acks.
REQ-026 o_data SHALL hold its value between read acks, including across writes and aborts.
REQ-027 A write then read to the same address SHALL return the new data; there is no bypass path, because the accesses are sequential.
REQ-028 Address SHALL wrap naturally within ADDR_WIDTH, with no out-of-range condition.
REQ-029 i_addr/i_data changes after acceptance SHALL have no effect on the current transfer.

Reset
REQ-030 While nRst is low, the FSM SHALL be in IDLE, the counter 0, and all array entries 0.
REQ-031 While nRst is low, o_read_ack, o_write_ack, o_busy and o_err SHALL be 0 and o_data SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no ack and no write; after release, the first accept needs a fresh IDLE sample.

Verification (ADDR_NIBBLES=1, DATA_NIBBLES=1, LATENCY=2 unless stated)
REQ-033 Scenario: after reset, read addr 0x5 -> o_read_ack high one cycle, 3 cycles after the accept edge, o_data=0x0.
REQ-034 Scenario: write 0xA to addr 0x3, then read 0x3 -> o_write_ack pulse, then o_read_ack with o_data=0xA; o_data holds 0xA afterwards.
REQ-035 Scenario: both requests high in IDLE, addr 0x7, data 0xC -> o_err pulse, write acked first; the read, still held, then acked with o_data=0xC.
REQ-036 Scenario: read addr 0x3 accepted, i_read_req dropped during WAIT -> no ack, FSM back in IDLE, o_data unchanged.
REQ-037 Scenario: LATENCY=0, swap sequence (read req, write req raised in the read-ack cycle, then read req raised in the write-ack cycle) -> each ack arrives 1 cycle after acceptance, with 1 idle cycle between acks.
REQ-038 Scenario: nRst pulsed low during WAIT of a write 0x9 to 0x1 -> no ack; a subsequent read of 0x1 returns 0x0.
